// File: rtl/board_renderer_pkg.sv
// Shared pacman definitions: cell codes, board geometry, VGA 640x480@60 timing
// and the renderer palette (RRRGGGBB).
package pacman_definitions;

  typedef enum logic [2:0] {
    empty_box          = 3'd0,
    food_box           = 3'd1,
    wall_box           = 3'd2,
    pacman_box         = 3'd3,
    ghost_box          = 3'd4,
    ghost_and_food_box = 3'd5
  } box_t;

  localparam int BOARD_WIDTH  = 32;
  localparam int BOARD_LENGTH = 24;
  localparam int CELL_PIX     = 20;
  localparam int CLK_DIV      = 4;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam logic [7:0] COL_BG     = 8'h00;
  localparam logic [7:0] COL_BG_GO  = 8'h60;
  localparam logic [7:0] COL_FOOD   = 8'hFF;
  localparam logic [7:0] COL_WALL   = 8'h03;
  localparam logic [7:0] COL_PACMAN = 8'hFC;
  localparam logic [7:0] COL_GHOST  = 8'hE0;
  localparam logic [7:0] COL_DEBUG  = 8'hE3;

  function automatic logic in_box(input logic [4:0] sx, input logic [4:0] sy,
                                  input logic [4:0] lo, input logic [4:0] hi);
    return (sx >= lo) && (sx <= hi) && (sy >= lo) && (sy <= hi);
  endfunction

  // Ghost wins over food in a shared cell, so both ghost codes draw the same.
  function automatic logic [7:0] cell_colour(input logic [2:0] code, input logic [4:0] sx,
                                             input logic [4:0] sy, input logic [7:0] bg);
    logic [7:0] c;
    c = bg;
    case (code)
      empty_box:          c = bg;
      food_box:           c = in_box(sx, sy, 5'd8, 5'd11) ? COL_FOOD : bg;
      wall_box:           c = COL_WALL;
      pacman_box:         c = in_box(sx, sy, 5'd2, 5'd17) ? COL_PACMAN : bg;
      ghost_box,
      ghost_and_food_box: c = in_box(sx, sy, 5'd2, 5'd17) ? COL_GHOST : bg;
      default:            c = COL_DEBUG;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/board_renderer_vga_timing.sv
// VGA raster generator: pixel-rate divider, hc/vc scan counters, sync decode
// and visible-region flags, all for the current (stage-0) pixel.
module vga_timing #(
  parameter int H_VIS  = pacman_definitions::H_VIS,
  parameter int H_FP   = pacman_definitions::H_FP,
  parameter int H_SYNC = pacman_definitions::H_SYNC,
  parameter int H_BP   = pacman_definitions::H_BP,
  parameter int V_VIS  = pacman_definitions::V_VIS,
  parameter int V_FP   = pacman_definitions::V_FP,
  parameter int V_SYNC = pacman_definitions::V_SYNC,
  parameter int V_BP   = pacman_definitions::V_BP
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic line_end,
  output logic frame_end,
  output logic h_active,
  output logic v_active,
  output logic hsync_n,
  output logic vsync_n,
  output logic frame_start
);
  import pacman_definitions::*;

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_q, div_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  assign pix_en      = (div_q == DIV_LAST);
  assign line_end    = (hc_q == H_LAST);
  assign frame_end   = line_end && (vc_q == V_LAST);
  assign h_active    = (hc_q < H_VIS_L);
  assign v_active    = (vc_q < V_VIS_L);
  assign hsync_n     = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vsync_n     = !((vc_q >= VS_START) && (vc_q < VS_END));
  assign frame_start = pix_en && (hc_q == 10'd0) && (vc_q == 10'd0);

  always_comb begin
    div_d = pix_en ? 2'd0 : div_q + 2'd1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (pix_en) begin
      if (line_end) begin
        hc_d = 10'd0;
        vc_d = frame_end ? 10'd0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 2'd0;
      hc_q  <= 10'd0;
      vc_q  <= 10'd0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Board renderer: walks the board cell grid in step with the VGA raster, reads
// each cell code and produces one-pixel-delayed RGB with matching syncs.
module board_renderer #(
  parameter int BOARD_WIDTH  = pacman_definitions::BOARD_WIDTH,
  parameter int BOARD_LENGTH = pacman_definitions::BOARD_LENGTH,
  parameter int H_VIS        = pacman_definitions::H_VIS,
  parameter int H_FP         = pacman_definitions::H_FP,
  parameter int H_SYNC       = pacman_definitions::H_SYNC,
  parameter int H_BP         = pacman_definitions::H_BP,
  parameter int V_VIS        = pacman_definitions::V_VIS,
  parameter int V_FP         = pacman_definitions::V_FP,
  parameter int V_SYNC       = pacman_definitions::V_SYNC,
  parameter int V_BP         = pacman_definitions::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] board_data,
  input  logic       game_over,
  output logic [5:0] x,
  output logic [5:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);
  import pacman_definitions::*;

  localparam logic [4:0] CELL_LAST = 5'(CELL_PIX - 1);
  localparam logic [4:0] COL_LAST  = 5'(BOARD_WIDTH - 1);
  localparam logic [4:0] ROW_LAST  = 5'(BOARD_LENGTH - 1);
  localparam logic [5:0] Y_TOP     = 6'(BOARD_LENGTH - 1);

  logic pix_en, line_end, frame_end, h_active, v_active, hsync_n, vsync_n;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .h_active    (h_active),
    .v_active    (v_active),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (frame_start)
  );

  logic [4:0] sub_x_q, sub_x_d, cell_col_q, cell_col_d;
  logic [4:0] sub_y_q, sub_y_d, cell_row_q, cell_row_d;
  logic [5:0] y_q, y_d;
  logic       go_q, go_d;
  logic [7:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    sub_x_d    = sub_x_q;
    cell_col_d = cell_col_q;
    sub_y_d    = sub_y_q;
    cell_row_d = cell_row_q;
    go_d       = go_q;
    rgb_d      = rgb_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    if (pix_en) begin
      if (line_end) begin
        sub_x_d    = 5'd0;
        cell_col_d = 5'd0;
        if (frame_end) begin
          sub_y_d    = 5'd0;
          cell_row_d = 5'd0;
        end else if (v_active) begin
          // Row index saturates so y parks on the bottom row through v-blank.
          if (sub_y_q == CELL_LAST) begin
            sub_y_d = 5'd0;
            if (cell_row_q != ROW_LAST) cell_row_d = cell_row_q + 5'd1;
          end else begin
            sub_y_d = sub_y_q + 5'd1;
          end
        end
      end else if (h_active) begin
        if (sub_x_q == CELL_LAST) begin
          sub_x_d = 5'd0;
          if (cell_col_q != COL_LAST) cell_col_d = cell_col_q + 5'd1;
        end else begin
          sub_x_d = sub_x_q + 5'd1;
        end
      end
      // Game-over only takes effect at a frame boundary to avoid tearing.
      if (frame_end) go_d = game_over;
      rgb_d   = (h_active && v_active)
                ? cell_colour(board_data, sub_x_q, sub_y_q, go_q ? COL_BG_GO : COL_BG)
                : 8'h00;
      hsync_d = hsync_n;
      vsync_d = vsync_n;
    end
    // Screen row 0 shows the top board row, board "up" being +y.
    y_d = Y_TOP - {1'b0, cell_row_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_x_q    <= 5'd0;
      cell_col_q <= 5'd0;
      sub_y_q    <= 5'd0;
      cell_row_q <= 5'd0;
      y_q        <= Y_TOP;
      go_q       <= 1'b0;
      rgb_q      <= 8'h00;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      sub_x_q    <= sub_x_d;
      cell_col_q <= cell_col_d;
      sub_y_q    <= sub_y_d;
      cell_row_q <= cell_row_d;
      y_q        <= y_d;
      go_q       <= go_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign x     = {1'b0, cell_col_q};
  assign y     = y_q;
  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer on a shrunken raster (3x2 cells of 20 px,
// 76x46 total) so several whole frames fit in a short run.
module tb_board_renderer;

  localparam int HT = 76;
  localparam int FT = 76 * 46;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_over = 1'b0;
  logic [2:0] board_data;
  logic [5:0] x, y;
  logic       hsync, vsync, frame_start;
  logic [7:0] rgb;

  int vectors = 0;
  int errors  = 0;
  int clk_cnt = 0;
  int c0      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  board_renderer #(
    .BOARD_WIDTH(3), .BOARD_LENGTH(2),
    .H_VIS(60), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(40), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .board_data  (board_data),
    .game_over   (game_over),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  // Top row (y=1): empty, wall, food. Bottom row (y=0): ghost, pacman, code 6.
  function automatic logic [2:0] stub_cell(input logic [5:0] cx, input logic [5:0] cy);
    logic [2:0] c;
    c = 3'd0;
    if (cy == 6'd1) begin
      if (cx == 6'd1) c = 3'd2;
      else if (cx == 6'd2) c = 3'd1;
    end else if (cy == 6'd0) begin
      if (cx == 6'd0) c = 3'd4;
      else if (cx == 6'd1) c = 3'd3;
      else if (cx == 6'd2) c = 3'd6;
    end
    return c;
  endfunction

  assign board_data = stub_cell(x, y);

  // Clock index after which counters hold pixel (h,v), and after which rgb shows it.
  function automatic int cur_k(input int h, input int v, input int f);
    return 4 * (f * FT + v * HT + h) + 2;
  endfunction
  function automatic int out_k(input int h, input int v, input int f);
    return 4 * (f * FT + v * HT + h) + 4;
  endfunction

  task automatic wait_k(input int k);
    while (clk_cnt < c0 + k) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    c0 = clk_cnt;
    vectors++; if (x !== 6'd0) begin errors++; $display("FAIL reset_x: x=%0d expected 0", x); end
    vectors++; if (y !== 6'd1) begin errors++; $display("FAIL reset_y: y=%0d expected 1", y); end
    vectors++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL reset_sync: hsync=%b vsync=%b expected 1 1", hsync, vsync); end
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb: rgb=%h expected 00", rgb); end
    vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: frame_start=%b expected 0", frame_start); end
    reset = 1'b0;
    wait_k(2);
    vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_early: frame_start=%b expected 0", frame_start); end
    wait_k(3);
    vectors++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_first_tick: frame_start=%b expected 1", frame_start); end
    wait_k(4);
    vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_one_clk: frame_start=%b expected 0", frame_start); end
  endtask

  task automatic test_row0;
    wait_k(cur_k(19, 0, 0));
    vectors++; if (x !== 6'd0) begin errors++; $display("FAIL addr_hc19: x=%0d expected 0", x); end
    wait_k(cur_k(20, 0, 0));
    vectors++; if (x !== 6'd1 || y !== 6'd1) begin errors++; $display("FAIL addr_hc20: x=%0d y=%0d expected 1 1", x, y); end
    wait_k(out_k(25, 0, 0));
    vectors++; if (rgb !== 8'h03) begin errors++; $display("FAIL rgb_wall: rgb=%h expected 03", rgb); end
    wait_k(out_k(45, 0, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL rgb_food_edge: rgb=%h expected 00", rgb); end
    wait_k(cur_k(59, 0, 0));
    vectors++; if (x !== 6'd2) begin errors++; $display("FAIL addr_last_col: x=%0d expected 2", x); end
    wait_k(out_k(64, 0, 0) - 1);
    vectors++; if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_pre: hsync=%b expected 1", hsync); end
    wait_k(out_k(64, 0, 0));
    vectors++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_fall: hsync=%b expected 0", hsync); end
    wait_k(cur_k(65, 0, 0));
    vectors++; if (x !== 6'd2) begin errors++; $display("FAIL addr_hblank_sat: x=%0d expected 2", x); end
    wait_k(out_k(72, 0, 0) - 1);
    vectors++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_last_low: hsync=%b expected 0", hsync); end
    wait_k(out_k(72, 0, 0));
    vectors++; if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_rise: hsync=%b expected 1", hsync); end
  endtask

  task automatic test_hsync_period;
    wait_k(out_k(64, 1, 0) - 1);
    vectors++; if (hsync !== 1'b1) begin errors++; $display("FAIL hsync_period_pre: hsync=%b expected 1", hsync); end
    wait_k(out_k(64, 1, 0));
    vectors++; if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_period_fall: hsync=%b expected 0", hsync); end
  endtask

  task automatic test_game_over_raise;
    wait_k(out_k(50, 9, 0));
    vectors++; if (rgb !== 8'hFF) begin errors++; $display("FAIL rgb_food_centre: rgb=%h expected ff", rgb); end
    wait_k(cur_k(5, 19, 0));
    vectors++; if (y !== 6'd1) begin errors++; $display("FAIL addr_vc19: y=%0d expected 1", y); end
    wait_k(cur_k(5, 20, 0));
    vectors++; if (y !== 6'd0) begin errors++; $display("FAIL addr_vc20: y=%0d expected 0", y); end
    game_over = 1'b1;
    wait_k(out_k(0, 21, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL go_no_tear: rgb=%h expected 00", rgb); end
  endtask

  task automatic test_sprite_bounds;
    wait_k(out_k(21, 21, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL pac_sub1: rgb=%h expected 00", rgb); end
    wait_k(out_k(22, 22, 0));
    vectors++; if (rgb !== 8'hFC) begin errors++; $display("FAIL pac_sub2: rgb=%h expected fc", rgb); end
    wait_k(out_k(45, 25, 0));
    vectors++; if (rgb !== 8'hE3) begin errors++; $display("FAIL rgb_debug: rgb=%h expected e3", rgb); end
    wait_k(out_k(62, 25, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL rgb_hblank: rgb=%h expected 00", rgb); end
    wait_k(out_k(30, 30, 0));
    vectors++; if (rgb !== 8'hFC) begin errors++; $display("FAIL pac_centre: rgb=%h expected fc", rgb); end
    wait_k(out_k(38, 30, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL pac_sub18: rgb=%h expected 00", rgb); end
    wait_k(out_k(37, 37, 0));
    vectors++; if (rgb !== 8'hFC) begin errors++; $display("FAIL pac_sub17: rgb=%h expected fc", rgb); end
    wait_k(cur_k(5, 39, 0));
    vectors++; if (y !== 6'd0) begin errors++; $display("FAIL addr_last_line: y=%0d expected 0", y); end
  endtask

  task automatic test_vsync;
    wait_k(out_k(0, 42, 0) - 1);
    vectors++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_pre: vsync=%b expected 1", vsync); end
    wait_k(out_k(0, 42, 0));
    vectors++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_fall: vsync=%b expected 0", vsync); end
    wait_k(out_k(45, 42, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL rgb_vblank: rgb=%h expected 00", rgb); end
    wait_k(out_k(75, 43, 0));
    vectors++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_last_low: vsync=%b expected 0", vsync); end
    wait_k(out_k(0, 44, 0));
    vectors++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_rise: vsync=%b expected 1", vsync); end
    wait_k(cur_k(3, 44, 0));
    vectors++; if (y !== 6'd0) begin errors++; $display("FAIL addr_vblank_sat: y=%0d expected 0", y); end
  endtask

  task automatic test_frame1_game_over;
    wait_k(4 * FT + 2);
    vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_f1_early: frame_start=%b expected 0", frame_start); end
    wait_k(4 * FT + 3);
    vectors++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_f1: frame_start=%b expected 1", frame_start); end
    wait_k(out_k(25, 0, 1));
    vectors++; if (rgb !== 8'h03) begin errors++; $display("FAIL go_wall: rgb=%h expected 03", rgb); end
    wait_k(out_k(45, 0, 1));
    vectors++; if (rgb !== 8'h60) begin errors++; $display("FAIL go_food_edge: rgb=%h expected 60", rgb); end
    wait_k(out_k(5, 5, 1));
    vectors++; if (rgb !== 8'h60) begin errors++; $display("FAIL go_empty: rgb=%h expected 60", rgb); end
    wait_k(out_k(0, 21, 1));
    vectors++; if (rgb !== 8'h60) begin errors++; $display("FAIL go_ghost_edge: rgb=%h expected 60", rgb); end
    wait_k(out_k(62, 25, 1));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL go_hblank: rgb=%h expected 00", rgb); end
    wait_k(out_k(10, 30, 1));
    vectors++; if (rgb !== 8'hE0) begin errors++; $display("FAIL go_ghost_centre: rgb=%h expected e0", rgb); end
    wait_k(out_k(30, 30, 1));
    vectors++; if (rgb !== 8'hFC) begin errors++; $display("FAIL go_pac_centre: rgb=%h expected fc", rgb); end
    wait_k(out_k(0, 42, 1) - 1);
    vectors++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_period_pre: vsync=%b expected 1", vsync); end
    wait_k(out_k(0, 42, 1));
    vectors++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_period_fall: vsync=%b expected 0", vsync); end
  endtask

  task automatic test_reset_midframe;
    wait_k(out_k(29, 10, 2));
    vectors++; if (rgb !== 8'h03) begin errors++; $display("FAIL pre_reset_rgb: rgb=%h expected 03", rgb); end
    wait_k(cur_k(30, 10, 2));
    vectors++; if (x !== 6'd1) begin errors++; $display("FAIL pre_reset_x: x=%0d expected 1", x); end
    reset = 1'b1;
    @(negedge clk);
    c0 = clk_cnt;
    reset = 1'b0;
    vectors++; if (x !== 6'd0 || y !== 6'd1) begin errors++; $display("FAIL mid_reset_xy: x=%0d y=%0d expected 0 1", x, y); end
    vectors++; if (rgb !== 8'h00 || hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL mid_reset_out: rgb=%h hsync=%b vsync=%b expected 00 1 1", rgb, hsync, vsync); end
    vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_reset_fs: frame_start=%b expected 0", frame_start); end
    wait_k(2);
    vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs_early: frame_start=%b expected 0", frame_start); end
    wait_k(3);
    vectors++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_fs_first: frame_start=%b expected 1", frame_start); end
    wait_k(out_k(25, 0, 0));
    vectors++; if (rgb !== 8'h03) begin errors++; $display("FAIL mid_restart_wall: rgb=%h expected 03", rgb); end
    wait_k(out_k(5, 5, 0));
    vectors++; if (rgb !== 8'h00) begin errors++; $display("FAIL mid_go_cleared: rgb=%h expected 00", rgb); end
  endtask

  initial begin
    test_reset();
    test_row0();
    test_hsync_period();
    test_game_over_raise();
    test_sprite_bounds();
    test_vsync();
    test_frame1_game_over();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time=%0t expected completion before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
